afe_lvds_tx_emu: RTL
====================

Name: afe_lvds_tx_emu

Overview:
Transmit-side emulator of the AFE5808A serial LVDS link: one data lane, frame clock and bit clock.
- Takes parallel ADC samples over a valid/ready stream and serializes them MSB- or LSB-first.
- Generates the matching frame clock (FCLK) and bit clock (DCLK) so the existing AFE deserializer path can be driven in loopback or board test without a physical AFE.
- Sits in fabric ahead of the OBUFDS pins; the whole block runs in the single `clk` domain.

Parameters:
- SAMPLE_WIDTH, 14: bits per sample/frame. Legal values are even only: 12, 14, 16.
- MSB_FIRST, 1: 1 = serialize bit SAMPLE_WIDTH-1 first; 0 = bit 0 first.
- IDLE_WORD, 0: word sent when no sample is available (startup or underflow).

Ports:
- clk, input, 1: single clock. One serial bit occupies 2 clk cycles.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: level; start/stop transmission at frame boundaries.
- s_tdata, input, SAMPLE_WIDTH: sample to send.
- s_tvalid, input, 1: s_tdata valid.
- s_tready, output, 1: sample accepted on the cycle where s_tvalid && s_tready.
- ser_data, output, 1: serial data bit.
- ser_fclk, output, 1: frame clock, high for the first SAMPLE_WIDTH/2 bits of each frame.
- ser_dclk, output, 1: bit clock; rising edge at the centre of each bit.
- frame_start, output, 1: one-cycle pulse coincident with bit 0 of each frame.
- underflow, output, 1: one-cycle pulse when IDLE_WORD is substituted in RUN.
- underflow_cnt, output, 16: saturating count of underflows; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0; phase 0; shift register = IDLE_WORD; underflow_cnt 0.
- Phase counter runs 0..2*SAMPLE_WIDTH-1 and wraps.
  - bit_idx = phase>>1; half = phase[0].
  - A frame is 2*SAMPLE_WIDTH cycles (28 for W=14).
- All outputs are registered.
  - ser_data changes only when half=0.
  - ser_dclk = half, so it rises mid-bit.
  - ser_fclk = (bit_idx < SAMPLE_WIDTH/2).
  - frame_start = (phase==0) in RUN.
- IDLE state:
  - Outputs held 0; s_tready = enable (combinational from state and enable).
  - On enable=1, move to RUN next cycle with phase 0. The shift register loads s_tdata if s_tvalid, else IDLE_WORD. No underflow is counted at startup.
- RUN state:
  - s_tready = 1 only when phase==2*SAMPLE_WIDTH-1 and enable=1.
  - On that cycle, if s_tvalid: load s_tdata.
  - Else: load IDLE_WORD, pulse underflow next cycle, and increment underflow_cnt (saturating at 16'hFFFF).
- Latency: the first bit of an accepted sample appears on ser_data the cycle after acceptance. Frames are back-to-back with no gaps.
- enable dropped mid-frame: the current frame completes; no sample is accepted at phase LAST. Go to IDLE at the wrap and drive outputs 0.
- enable re-asserted on the same cycle as the wrap: stay in RUN, with normal accept.
- Holding s_tvalid while s_tready=0 has no effect; s_tdata is sampled only on handshake.
- Reset asserted mid-frame: outputs drop to 0 immediately. The partial frame is discarded.

Optional Feature:
- Macro AFE_TX_TESTPAT_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, the load source at each frame boundary is an internal SAMPLE_WIDTH-bit ramp, incremented per frame and wrapping at all-ones→0.
  - s_tready is held 0 and underflow is never signalled.
  - The ramp resets to 0 on reset and on IDLE→RUN.
- Undefined: no test_mode port; behaviour exactly as above.

Decomposition:
- Package afe_tx_pkg:
  - State enum {IDLE, RUN}.
  - Constants AFE_DEF_WIDTH=14 and UFLOW_CNT_W=16.
  - Function giving phase counter width, $clog2(2*SAMPLE_WIDTH).
- Sub-module afe_tx_timing: phase counter plus the fclk/dclk/frame_start generation.
- The top level holds the FSM, handshake, shift register and underflow logic.

Test Plan:
1. W=14, MSB_FIRST=1, enable=1, constant valid 14'h2A5C → ser_data across 28 cycles = 10101001011100, each bit held 2 cycles; ser_fclk high for 14 cycles, then low for 14; one frame_start pulse per 28 cycles.
2. Stream 14'h0001, 14'h2000 back-to-back → s_tready pulses exactly at phase 27. The next frame starts at the following cycle with no gap. Decoded words match.
3. s_tvalid low for 3 frames in RUN → IDLE_WORD sent 3 times; 3 underflow pulses; underflow_cnt=3. Startup with no valid → count stays 0.
4. enable dropped at phase 10 → frame finishes through phase 27, then outputs go 0. s_tready is never asserted after the drop.
5. reset_n low at phase 15 → all outputs 0 within the same cycle (async). After release with enable=1, transmission restarts at phase 0.
6. AFE_TX_TESTPAT_EN defined, test_mode=1 → successive frames decode to 0, 1, 2, …; after 16383 the ramp wraps to 0. s_tready stays 0.

Source files
------------

// File: rtl/afe_tx_pkg.sv
// Shared types and constants for the AFE5808A LVDS transmit emulator.
package afe_tx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tx_state_e;

   localparam int AFE_DEF_WIDTH = 14;
   localparam int UFLOW_CNT_W   = 16;

   function automatic int phase_width(input int sample_width);
      return $clog2(2 * sample_width);
   endfunction

endpackage

// File: rtl/afe_tx_timing.sv
// Frame phase counter with registered FCLK, DCLK and frame_start generation.
// Outputs are computed from the next phase so they line up with the data register.
module afe_tx_timing
   import afe_tx_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AFE_DEF_WIDTH
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic run_nxt,
   output logic last,
   output logic bit_edge,
   output logic fclk,
   output logic dclk,
   output logic frame_start
);

   localparam int PW = phase_width(SAMPLE_WIDTH);
   localparam logic [PW-1:0] PHASE_LAST = PW'(2 * SAMPLE_WIDTH - 1);
   localparam logic [PW-2:0] FCLK_BITS  = (PW-1)'(SAMPLE_WIDTH / 2);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;

   assign last = run && (phase == PHASE_LAST);

   always_comb begin
      phase_nxt = '0;
      if (run && run_nxt && (phase != PHASE_LAST)) begin
         phase_nxt = phase + PW'(1);
      end
   end

   // next cycle starts a new bit: the data register may advance
   assign bit_edge = run_nxt && !phase_nxt[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase       <= '0;
         fclk        <= 1'b0;
         dclk        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         phase       <= phase_nxt;
         fclk        <= run_nxt && (phase_nxt[PW-1:1] < FCLK_BITS);
         dclk        <= run_nxt && phase_nxt[0];
         frame_start <= run_nxt && (phase_nxt == '0);
      end
   end

endmodule

// File: rtl/afe_lvds_tx_emu.sv
// AFE5808A serial LVDS transmit emulator: FSM, stream handshake, shift register, underflow.
// Optional ramp test pattern enabled by defining AFE_TX_TESTPAT_EN (adds test_mode input).
//
//   state | meaning
//   IDLE  | link quiet, all outputs 0, s_tready follows enable
//   RUN   | frames back-to-back, new word loaded at the last phase of each frame
module afe_lvds_tx_emu
   import afe_tx_pkg::*;
#(
   parameter int                      SAMPLE_WIDTH = AFE_DEF_WIDTH,
   parameter bit                      MSB_FIRST    = 1'b1,
   parameter logic [SAMPLE_WIDTH-1:0] IDLE_WORD    = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
`ifdef AFE_TX_TESTPAT_EN
   input  logic                    test_mode,
`endif
   input  logic [SAMPLE_WIDTH-1:0] s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   output logic                    ser_data,
   output logic                    ser_fclk,
   output logic                    ser_dclk,
   output logic                    frame_start,
   output logic                    underflow,
   output logic [UFLOW_CNT_W-1:0]  underflow_cnt
);

   tx_state_e               state;
   tx_state_e               state_nxt;
   logic                    run;
   logic                    run_nxt;
   logic                    last;
   logic                    bit_edge;
   logic                    test_on;
   logic                    load;
   logic                    starve;
   logic [SAMPLE_WIDTH-1:0] load_word;
   logic [SAMPLE_WIDTH-1:0] shift_reg;

   function automatic logic head_bit(input logic [SAMPLE_WIDTH-1:0] w);
      return MSB_FIRST ? w[SAMPLE_WIDTH-1] : w[0];
   endfunction

   function automatic logic [SAMPLE_WIDTH-1:0] shift_out(input logic [SAMPLE_WIDTH-1:0] w);
      return MSB_FIRST ? {w[SAMPLE_WIDTH-2:0], 1'b0} : {1'b0, w[SAMPLE_WIDTH-1:1]};
   endfunction

`ifdef AFE_TX_TESTPAT_EN
   logic [SAMPLE_WIDTH-1:0] ramp;
   assign test_on = test_mode;
`else
   assign test_on = 1'b0;
`endif

   assign run     = (state == RUN);
   assign run_nxt = (state_nxt == RUN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (last && !enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // a load happens exactly at frame boundaries that keep the link running
   always_comb begin
      load     = 1'b0;
      s_tready = 1'b0;
      if (state == IDLE) begin
         load     = enable;
         s_tready = reset_n && enable && !test_on;
      end else if (last && enable) begin
         load     = 1'b1;
         s_tready = reset_n && !test_on;
      end
   end

   always_comb begin
      load_word = s_tvalid ? s_tdata : IDLE_WORD;
      starve    = run && !s_tvalid;
`ifdef AFE_TX_TESTPAT_EN
      if (test_on) begin
         load_word = run ? ramp : '0;
         starve    = 1'b0;
      end
`endif
   end

`ifdef AFE_TX_TESTPAT_EN
   // startup frame carries 0, so the ramp register already holds the next value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ramp <= '0;
      end else if (load && !run) begin
         ramp <= test_on ? SAMPLE_WIDTH'(1) : '0;
      end else if (load && test_on) begin
         ramp <= ramp + SAMPLE_WIDTH'(1);
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg     <= IDLE_WORD;
         ser_data      <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         underflow <= load && starve;
         if (load && starve && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + UFLOW_CNT_W'(1);
         end
         if (load) begin
            ser_data  <= head_bit(load_word);
            shift_reg <= shift_out(load_word);
         end else if (bit_edge) begin
            ser_data  <= head_bit(shift_reg);
            shift_reg <= shift_out(shift_reg);
         end else if (!run_nxt) begin
            ser_data  <= 1'b0;
         end
      end
   end

   afe_tx_timing #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
   ) u_timing (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .run_nxt     (run_nxt),
      .last        (last),
      .bit_edge    (bit_edge),
      .fclk        (ser_fclk),
      .dclk        (ser_dclk),
      .frame_start (frame_start)
   );

endmodule
